// File: rtl/ifu_fetch_buffer.sv
// Instruction fetch stage: owns the PC, reads a combinational instruction memory and queues {pc, word} for decode.
// Latency: a word fetched at edge N appears on inst_o/pc_o at N+1; sustained rate of one word per cycle.
// Backpressure: fetch stalls while the queue is full and decode holds ready_i low; the head entry holds stable until taken.
module ifu_fetch_buffer #(
    parameter int                ADDR_W   = 64,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,

    // instruction memory read port (combinational return)
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,

    // decode side
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              valid_o,
    input  logic              ready_i,

    // control flow and halt
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              finish_i,
    output logic              halted_o,
    output logic              misalign_o,
    output logic [31:0]       fetch_cnt_o
);

    // Pointers rely on natural binary wrap, so DEPTH must be a power of two.
    localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic              halted_q,    halted_d;
    logic              misalign_q,  misalign_d;
    logic [31:0]       fetch_cnt_q, fetch_cnt_d;

    // Entry storage: PC and instruction word kept side by side per slot.
    logic [ADDR_W-1:0] pc_buf_q   [DEPTH];
    logic [DATA_W-1:0] inst_buf_q [DEPTH];

    // ------------------------------------------------------------------
    // Handshake terms
    // ------------------------------------------------------------------
    logic empty;
    logic full;
    logic pop;
    logic push;

    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_C);

    // A redirect flushes the queue, so the head is not consumed in that cycle.
    assign pop  = ~empty & ready_i & ~redirect_i;

    // A pop in the same cycle frees a slot, which keeps a full queue streaming.
    assign push = ~halted_q & ~finish_i & ~redirect_i & (~full | pop);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign mem_addr_o  = pc_q;
    assign valid_o     = ~empty;
    assign inst_o      = inst_buf_q[rd_ptr_q];
    assign pc_o        = pc_buf_q[rd_ptr_q];
    assign halted_o    = halted_q;
    assign misalign_o  = misalign_q;
    assign fetch_cnt_o = fetch_cnt_q;

    // Next-state: redirect overrides everything except the sticky halt/misalign flags.
    always_comb begin
        pc_d        = pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        halted_d    = halted_q | finish_i;
        misalign_d  = misalign_q;
        fetch_cnt_d = fetch_cnt_q;

        if (redirect_i) begin
            // Low address bits are dropped; a nonzero value is recorded as misaligned.
            pc_d     = {redirect_pc_i[ADDR_W-1:2], 2'b00};
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            if (redirect_pc_i[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else begin
            if (push) begin
                pc_d        = pc_q + ADDR_W'(4);
                wr_ptr_d    = wr_ptr_q + PTR_W'(1);
                fetch_cnt_d = fetch_cnt_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q        <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            halted_q    <= 1'b0;
            misalign_q  <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            halted_q    <= halted_d;
            misalign_q  <= misalign_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // Entry storage needs no reset; count gates every read of it.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            pc_buf_q[wr_ptr_q]   <= pc_q;
            inst_buf_q[wr_ptr_q] <= mem_data_i;
        end
    end

endmodule

// File: tb/tb_ifu_fetch_buffer.sv
// Bench for ifu_fetch_buffer: byte-pattern instruction memory, queue scoreboard on the decode handshake.
// Expected {pc, word} entries are queued when a fetch stream is started (reset or redirect) and popped on every accepted beat.
// Inputs change 1 time unit after the rising edge; the scoreboard samples on the falling edge.
module tb_ifu_fetch_buffer;

    localparam int AW = 64;
    localparam int DW = 32;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_i;
    logic [DW-1:0] inst_o;
    logic [AW-1:0] pc_o;
    logic          valid_o;
    logic          ready_i;
    logic          redirect_i;
    logic [AW-1:0] redirect_pc_i;
    logic          finish_i;
    logic          halted_o;
    logic          misalign_o;
    logic [31:0]   fetch_cnt_o;

    logic [7:0] mem [256];
    ent_t       exp_q[$];
    ent_t       sb_e;
    int         checks  = 0;
    int         errors  = 0;
    int         pop_cnt = 0;
    logic [AW-1:0] frozen_pc;

    always #5 clk = ~clk;

    ifu_fetch_buffer #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (2),
        .RESET_PC (64'h0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .mem_addr_o    (mem_addr_o),
        .mem_data_i    (mem_data_i),
        .inst_o        (inst_o),
        .pc_o          (pc_o),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .finish_i      (finish_i),
        .halted_o      (halted_o),
        .misalign_o    (misalign_o),
        .fetch_cnt_o   (fetch_cnt_o)
    );

    // Little-endian 32-bit read from a 256-byte image that wraps.
    function automatic logic [31:0] word_at(input logic [AW-1:0] a);
        logic [7:0] b;
        b = a[7:0];
        return {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
    endfunction

    always_comb mem_data_i = word_at(mem_addr_o);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_stream(input logic [AW-1:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back({start + AW'(4 * i), word_at(start + AW'(4 * i))});
        end
    endtask

    task automatic do_reset(input logic rdy);
        rst_i      = 1'b1;
        redirect_i = 1'b0;
        finish_i   = 1'b0;
        ready_i    = rdy;
        tick();
        tick();
    endtask

    // Scoreboard: every accepted beat must match the next expected entry.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_i && valid_o && ready_i && !redirect_i) begin
                pop_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected got pc %h inst %h, required no beat", pc_o, inst_o);
                end else begin
                    sb_e = exp_q.pop_front();
                    if (pc_o !== sb_e.pc || inst_o !== sb_e.inst) begin
                        errors++;
                        $display("FAIL sb_entry got pc %h inst %h, required pc %h inst %h",
                                 pc_o, inst_o, sb_e.pc, sb_e.inst);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++; if (valid_o !== 1'b0)      begin errors++; $display("FAIL rst_valid got %b, required 0", valid_o); end
        checks++; if (halted_o !== 1'b0)     begin errors++; $display("FAIL rst_halted got %b, required 0", halted_o); end
        checks++; if (misalign_o !== 1'b0)   begin errors++; $display("FAIL rst_misalign got %b, required 0", misalign_o); end
        checks++; if (fetch_cnt_o !== 32'd0) begin errors++; $display("FAIL rst_fetch_cnt got %0d, required 0", fetch_cnt_o); end
        checks++; if (mem_addr_o !== 64'h0)  begin errors++; $display("FAIL rst_addr got %h, required 0", mem_addr_o); end
    endtask

    task automatic test_stream();
        do_reset(1'b1);
        load_stream(64'h0);
        rst_i = 1'b0;
        checks++; if (valid_o !== 1'b0 || mem_addr_o !== 64'h0) begin errors++; $display("FAIL stream_start got valid %b addr %h, required 0 0", valid_o, mem_addr_o); end
        tick();
        checks++; if (valid_o !== 1'b1 || inst_o !== 32'h03020100 || pc_o !== 64'h0) begin
            errors++; $display("FAIL stream_first got valid %b inst %h pc %h, required 1 03020100 0", valid_o, inst_o, pc_o); end
        checks++; if (mem_addr_o !== 64'h4) begin errors++; $display("FAIL stream_addr1 got %h, required 4", mem_addr_o); end
        tick();
        checks++; if (inst_o !== 32'h07060504 || pc_o !== 64'h4) begin
            errors++; $display("FAIL stream_second got inst %h pc %h, required 07060504 4", inst_o, pc_o); end
        checks++; if (mem_addr_o !== 64'h8) begin errors++; $display("FAIL stream_addr2 got %h, required 8", mem_addr_o); end
    endtask

    task automatic test_backpressure();
        do_reset(1'b0);
        load_stream(64'h0);
        rst_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (valid_o !== 1'b1 || inst_o !== 32'h03020100 || pc_o !== 64'h0) begin
                errors++; $display("FAIL bp_hold cyc %0d got valid %b inst %h pc %h, required 1 03020100 0", i, valid_o, inst_o, pc_o); end
        end
        checks++; if (mem_addr_o !== 64'h8) begin errors++; $display("FAIL bp_addr got %h, required 8", mem_addr_o); end
        checks++; if (fetch_cnt_o !== 32'd2) begin errors++; $display("FAIL bp_cnt_full got %0d, required 2", fetch_cnt_o); end
        ready_i = 1'b1;
        pop_cnt = 0;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (pop_cnt !== 10) begin errors++; $display("FAIL bp_pops got %0d, required 10", pop_cnt); end
        checks++; if (fetch_cnt_o !== 32'd12) begin errors++; $display("FAIL bp_cnt got %0d, required 12", fetch_cnt_o); end
        checks++; if (mem_addr_o !== 64'h30) begin errors++; $display("FAIL bp_addr_end got %h, required 30", mem_addr_o); end
    endtask

    task automatic test_redirect();
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h40;
        tick();
        redirect_i = 1'b0;
        load_stream(64'h40);
        checks++; if (valid_o !== 1'b0 || mem_addr_o !== 64'h40) begin
            errors++; $display("FAIL redir_flush got valid %b addr %h, required 0 40", valid_o, mem_addr_o); end
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL redir_misalign got %b, required 0", misalign_o); end
        tick();
        checks++; if (valid_o !== 1'b1 || pc_o !== 64'h40 || inst_o !== 32'h43424140) begin
            errors++; $display("FAIL redir_first got valid %b pc %h inst %h, required 1 40 43424140", valid_o, pc_o, inst_o); end
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_misalign();
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h43;
        tick();
        redirect_i = 1'b0;
        load_stream(64'h40);
        checks++; if (mem_addr_o !== 64'h40 || misalign_o !== 1'b1) begin
            errors++; $display("FAIL mis_set got addr %h misalign %b, required 40 1", mem_addr_o, misalign_o); end
        for (int i = 0; i < 3; i++) tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h80;
        tick();
        redirect_i = 1'b0;
        load_stream(64'h80);
        checks++; if (mem_addr_o !== 64'h80 || misalign_o !== 1'b1) begin
            errors++; $display("FAIL mis_sticky got addr %h misalign %b, required 80 1", mem_addr_o, misalign_o); end
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_finish();
        ready_i = 1'b0;
        tick();
        finish_i = 1'b1;
        ready_i  = 1'b1;
        tick();
        finish_i = 1'b0;
        checks++; if (halted_o !== 1'b1 || valid_o !== 1'b1) begin
            errors++; $display("FAIL fin_halt got halted %b valid %b, required 1 1", halted_o, valid_o); end
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL fin_drain got valid %b, required 0", valid_o); end
        frozen_pc = (exp_q.size() > 0) ? exp_q[0].pc : 64'hDEAD;
        checks++; if (mem_addr_o !== frozen_pc) begin errors++; $display("FAIL fin_addr got %h, required %h", mem_addr_o, frozen_pc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (valid_o !== 1'b0 || mem_addr_o !== frozen_pc) begin
                errors++; $display("FAIL fin_frozen got valid %b addr %h, required 0 %h", valid_o, mem_addr_o, frozen_pc); end
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h0;
        tick();
        redirect_i = 1'b0;
        exp_q.delete();
        checks++; if (mem_addr_o !== 64'h0 || halted_o !== 1'b1 || valid_o !== 1'b0) begin
            errors++; $display("FAIL fin_redir got addr %h halted %b valid %b, required 0 1 0", mem_addr_o, halted_o, valid_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (valid_o !== 1'b0 || mem_addr_o !== 64'h0) begin
                errors++; $display("FAIL fin_nofetch got valid %b addr %h, required 0 0", valid_o, mem_addr_o); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        rst_i         = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h1;
        tick();
        redirect_i = 1'b0;
        load_stream(64'h0);
        tick();
        tick();
        finish_i = 1'b1;
        tick();
        finish_i = 1'b0;
        checks++; if (halted_o !== 1'b1 || valid_o !== 1'b1 || fetch_cnt_o !== 32'd2 || misalign_o !== 1'b1) begin
            errors++; $display("FAIL mid_pre got halted %b valid %b cnt %0d misalign %b, required 1 1 2 1",
                               halted_o, valid_o, fetch_cnt_o, misalign_o); end
        rst_i = 1'b1;
        tick();
        checks++; if (valid_o !== 1'b0 || halted_o !== 1'b0 || fetch_cnt_o !== 32'd0 || mem_addr_o !== 64'h0 || misalign_o !== 1'b0) begin
            errors++; $display("FAIL mid_rst got valid %b halted %b cnt %0d addr %h misalign %b, required 0 0 0 0 0",
                               valid_o, halted_o, fetch_cnt_o, mem_addr_o, misalign_o); end
        rst_i   = 1'b0;
        ready_i = 1'b1;
        load_stream(64'h0);
        tick();
        checks++; if (valid_o !== 1'b1 || pc_o !== 64'h0 || inst_o !== 32'h03020100) begin
            errors++; $display("FAIL mid_restart got valid %b pc %h inst %h, required 1 0 03020100", valid_o, pc_o, inst_o); end
        for (int i = 0; i < 4; i++) tick();
        checks++; if (fetch_cnt_o !== 32'd5) begin errors++; $display("FAIL mid_cnt got %0d, required 5", fetch_cnt_o); end
    endtask

    task automatic test_redirect_finish();
        redirect_i    = 1'b1;
        redirect_pc_i = 64'h20;
        finish_i      = 1'b1;
        tick();
        redirect_i = 1'b0;
        finish_i   = 1'b0;
        exp_q.delete();
        checks++; if (valid_o !== 1'b0 || halted_o !== 1'b1 || mem_addr_o !== 64'h20) begin
            errors++; $display("FAIL rf_both got valid %b halted %b addr %h, required 0 1 20", valid_o, halted_o, mem_addr_o); end
        tick();
        tick();
        checks++; if (valid_o !== 1'b0 || mem_addr_o !== 64'h20) begin
            errors++; $display("FAIL rf_stopped got valid %b addr %h, required 0 20", valid_o, mem_addr_o); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        rst_i         = 1'b1;
        ready_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        finish_i      = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_misalign();
        test_finish();
        test_reset_mid();
        test_redirect_finish();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
